// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch/decode front end: reset and bubble
// constants, the IF/ID register layout, the next-PC source encoding and
// small address helpers used by the fetch stage.
package mips_pkg;

  // Address fetched on the first cycle after reset.
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // sll $0,$0,0 -- the canonical MIPS no-op used for bubbles.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Opcode class the decoder reports for J/JAL.
  localparam logic [2:0] OPC_CLASS_J = 3'b100;

  // Sequential fetch step in bytes.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  // Which source wins the next-PC selection this cycle.
  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_HOLD   = 2'b01,
    SEL_BRANCH = 2'b10,
    SEL_JUMP   = 2'b11
  } pc_sel_e;

  // J-type target: top nibble of the delay-slot PC, 26-bit index, word aligned.
  function automatic logic [31:0] jump_target(input logic [3:0]  pc4_hi,
                                              input logic [25:0] index);
    return {pc4_hi, index, 2'b00};
  endfunction

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_stage_pc_next_sel.sv
// Next-PC priority mux for the fetch stage. Picks between reset-free
// sources (EX branch, ID jump, hazard hold, sequential) and tells the
// IF/ID register whether to load, hold or squash.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        jump_en_i,
  input  logic [25:0] jump_index_i,
  input  logic [3:0]  ifid_pc4_hi_i,
  input  logic        ifid_valid_i,
  output logic [31:0] pc_d_o,
  output logic [31:0] pc_plus4_o,
  output pc_sel_e     sel_o,
  output logic        flush_o,
  output logic        hold_o
);

  pc_sel_e sel;

  // The branch comes from the older EX instruction so it beats the jump;
  // a jump only counts when the ID slot holds a real instruction; both
  // redirects beat the hazard hold.
  always_comb begin
    sel = SEL_SEQ;
    if (br_taken_i) begin
      sel = SEL_BRANCH;
    end else if (jump_en_i && ifid_valid_i) begin
      sel = SEL_JUMP;
    end else if (stall_i) begin
      sel = SEL_HOLD;
    end
  end

  // Turn the selected source into the next PC and the IF/ID control pair.
  always_comb begin
    pc_plus4_o = pc_i + PC_STEP;
    pc_d_o     = pc_plus4_o;
    flush_o    = 1'b0;
    hold_o     = 1'b0;
    unique case (sel)
      SEL_BRANCH: begin
        pc_d_o  = word_align(br_target_i);
        flush_o = 1'b1;
      end
      SEL_JUMP: begin
        pc_d_o  = jump_target(ifid_pc4_hi_i, jump_index_i);
        flush_o = 1'b1;
      end
      SEL_HOLD: begin
        pc_d_o = pc_i;
        hold_o = 1'b1;
      end
      default: begin
        pc_d_o = pc_plus4_o;
      end
    endcase
  end

  assign sel_o = sel;

endmodule

// File: rtl/if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS
// core. Owns the PC, addresses the asynchronous-read instruction memory and
// captures the fetched word with its PC+4 for the decoder.
// Optional build macro: IFID_PERF_CNT_EN adds saturating stall_cnt and
// flush_cnt event counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  import mips_pkg::*;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  ifid_t       ifid_q;
  ifid_t       ifid_d;
  pc_sel_e     sel;
  logic        flush;
  logic        hold;

  pc_next_sel u_pc_next_sel (
    .pc_i          (pc_q),
    .stall_i       (stall),
    .br_taken_i    (br_taken),
    .br_target_i   (br_target),
    .jump_en_i     (jump_en),
    .jump_index_i  (jump_index),
    .ifid_pc4_hi_i (ifid_q.pc4[31:28]),
    .ifid_valid_i  (ifid_q.valid),
    .pc_d_o        (pc_d),
    .pc_plus4_o    (pc_plus4),
    .sel_o         (sel),
    .flush_o       (flush),
    .hold_o        (hold)
  );

  // Next IF/ID contents: squash on redirect, keep on hold, else capture
  // the word imem returns for the current PC. The PC+4 field is left as is
  // on a squash since nothing consumes it while valid is low.
  always_comb begin
    ifid_d = ifid_q;
    if (flush) begin
      ifid_d.inst  = NOP_INST;
      ifid_d.valid = 1'b0;
    end else if (!hold) begin
      ifid_d.inst  = imem_rdata;
      ifid_d.pc4   = pc_plus4;
      ifid_d.valid = 1'b1;
    end
  end

  // PC and IF/ID register; reset wins over every pipeline control.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ifid_q.inst  <= NOP_INST;
      ifid_q.pc4   <= 32'h0000_0000;
      ifid_q.valid <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign ifid_inst  = ifid_q.inst;
  assign ifid_pc4   = ifid_q.pc4;
  assign ifid_valid = ifid_q.valid;

  // Branch targets are forced to word alignment, so the low bits are dropped.
  logic unused_br_lsbs;
  assign unused_br_lsbs = ^br_target[1:0];

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Event counters: a stall only counts when no redirect overrode it, and
  // both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'h0000_0000;
      flush_cnt_q <= 32'h0000_0000;
    end else begin
      if ((sel == SEL_HOLD) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage. A behavioural model runs alongside
// the DUT; every driven cycle pushes the expected post-edge state into a
// queue that each scenario task pops and compares after the edge.
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump_en;
  logic [25:0] jump_index;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mPc;
  logic [31:0] mInst;
  logic [31:0] mPc4;
  logic        mValid;
  logic [31:0] mSc;
  logic [31:0] mFc;

  if_id_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jump_en    (jump_en),
    .jump_index (jump_index),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .ifid_inst  (ifid_inst),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Small instruction memory: the test program words, then an address hash.
  function automatic logic [31:0] imemModel(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h2009_0003;
      32'h0000_0008: return 32'h0109_5020;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign imem_rdata = imemModel(imem_addr);

  // Drive one cycle of stimulus, advance the model, queue its prediction,
  // and return 1 ns after the rising edge.
  task automatic applyStimulus(input logic r, input logic s, input logic b,
                               input logic [31:0] bt, input logic j,
                               input logic [25:0] ji);
    exp_t        e;
    logic [31:0] fetched;
    rst        = r;
    stall      = s;
    br_taken   = b;
    br_target  = bt;
    jump_en    = j;
    jump_index = ji;
    fetched    = imemModel(mPc);
    if (r) begin
      mPc = 32'h0; mInst = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
      mSc = 32'h0; mFc = 32'h0;
    end else if (b) begin
      mPc = bt & 32'hFFFF_FFFC; mInst = 32'h0; mValid = 1'b0;
      if (mFc != 32'hFFFF_FFFF) mFc = mFc + 1;
    end else if (j && mValid) begin
      mPc = {mPc4[31:28], ji, 2'b00}; mInst = 32'h0; mValid = 1'b0;
      if (mFc != 32'hFFFF_FFFF) mFc = mFc + 1;
    end else if (s) begin
      if (mSc != 32'hFFFF_FFFF) mSc = mSc + 1;
    end else begin
      mInst = fetched; mPc4 = mPc + 32'd4; mPc = mPc + 32'd4; mValid = 1'b1;
    end
    e.pc = mPc; e.inst = mInst; e.pc4 = mPc4; e.valid = mValid;
    e.sc = mSc; e.fc = mFc;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    e = expQ.pop_front();
    checks++;
    if ({imem_addr, ifid_inst, ifid_pc4, ifid_valid} !== {e.pc, e.inst, e.pc4, e.valid}) begin
      errors++;
      $display("[TB] FAIL reset_state got pc=%h inst=%h pc4=%h v=%b exp pc=%h inst=%h pc4=%h v=%b",
               imem_addr, ifid_inst, ifid_pc4, ifid_valid, e.pc, e.inst, e.pc4, e.valid);
    end
    checks++;
    if ({imem_addr, ifid_valid} !== {32'h0000_0000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_const got pc=%h v=%b exp pc=00000000 v=0", imem_addr, ifid_valid);
    end
  endtask

  task automatic test_sequential();
    exp_t        e;
    logic [31:0] wantAddr [3] = '{32'h4, 32'h8, 32'hC};
    logic [31:0] wantInst [3] = '{32'h2008_0005, 32'h2009_0003, 32'h0109_5020};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
      e = expQ.pop_front();
      checks++;
      if ({imem_addr, ifid_inst, ifid_pc4, ifid_valid} !== {e.pc, e.inst, e.pc4, e.valid}) begin
        errors++;
        $display("[TB] FAIL seq_model[%0d] got pc=%h inst=%h pc4=%h v=%b exp pc=%h inst=%h pc4=%h v=%b",
                 i, imem_addr, ifid_inst, ifid_pc4, ifid_valid, e.pc, e.inst, e.pc4, e.valid);
      end
      checks++;
      if ({imem_addr, ifid_inst, ifid_pc4} !== {wantAddr[i], wantInst[i], wantAddr[i]}) begin
        errors++;
        $display("[TB] FAIL seq_const[%0d] got pc=%h inst=%h pc4=%h exp pc=%h inst=%h pc4=%h",
                 i, imem_addr, ifid_inst, ifid_pc4, wantAddr[i], wantInst[i], wantAddr[i]);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    void'(expQ.pop_front());
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    void'(expQ.pop_front());
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    void'(expQ.pop_front());
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, (i < 2), 1'b0, 32'h0, 1'b0, 26'h0);
      e = expQ.pop_front();
      checks++;
      if ({imem_addr, ifid_inst, ifid_valid} !== {e.pc, e.inst, e.valid}) begin
        errors++;
        $display("[TB] FAIL stall_model[%0d] got pc=%h inst=%h v=%b exp pc=%h inst=%h v=%b",
                 i, imem_addr, ifid_inst, ifid_valid, e.pc, e.inst, e.valid);
      end
      checks++;
      if (imem_addr !== ((i < 2) ? 32'h8 : 32'hC)) begin
        errors++;
        $display("[TB] FAIL stall_addr[%0d] got %h exp %h", i, imem_addr, (i < 2) ? 32'h8 : 32'hC);
      end
      if (i < 2) begin
        checks++;
        if (ifid_inst !== 32'h2009_0003) begin
          errors++;
          $display("[TB] FAIL stall_inst[%0d] got %h exp 20090003", i, ifid_inst);
        end
      end
    end
  endtask

  task automatic test_jump();
    exp_t e;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_000C, 1'b0, 26'h0);
    void'(expQ.pop_front());
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    e = expQ.pop_front();
    checks++;
    if ({ifid_pc4, ifid_valid, ifid_inst} !== {32'h0040_0010, 1'b1, e.inst}) begin
      errors++;
      $display("[TB] FAIL jump_setup got pc4=%h v=%b inst=%h exp pc4=00400010 v=1 inst=%h",
               ifid_pc4, ifid_valid, ifid_inst, e.inst);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h010_0008);
    e = expQ.pop_front();
    checks++;
    if ({imem_addr, ifid_inst, ifid_valid} !== {32'h0040_0020, 32'h0, 1'b0}
        || e.pc !== 32'h0040_0020) begin
      errors++;
      $display("[TB] FAIL jump_taken got pc=%h inst=%h v=%b exp pc=00400020 inst=00000000 v=0",
               imem_addr, ifid_inst, ifid_valid);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h3FF_FFFF);
    e = expQ.pop_front();
    checks++;
    if ({imem_addr, ifid_pc4, ifid_valid, ifid_inst} !== {e.pc, e.pc4, e.valid, e.inst}) begin
      errors++;
      $display("[TB] FAIL jump_on_bubble got pc=%h pc4=%h v=%b inst=%h exp pc=%h pc4=%h v=%b inst=%h",
               imem_addr, ifid_pc4, ifid_valid, ifid_inst, e.pc, e.pc4, e.valid, e.inst);
    end
  endtask

  task automatic test_branch_priority();
    exp_t e;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    void'(expQ.pop_front());
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b1, 26'h155_5555);
    e = expQ.pop_front();
    checks++;
    if ({imem_addr, ifid_inst, ifid_valid} !== {32'h0000_0100, 32'h0, 1'b0}
        || e.pc !== 32'h0000_0100) begin
      errors++;
      $display("[TB] FAIL branch_priority got pc=%h inst=%h v=%b exp pc=00000100 inst=00000000 v=0",
               imem_addr, ifid_inst, ifid_valid);
    end
  endtask

  task automatic test_wrap_reset();
    exp_t e;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0);
    void'(expQ.pop_front());
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    e = expQ.pop_front();
    checks++;
    if ({imem_addr, ifid_pc4, ifid_valid, ifid_inst} !== {32'h0, 32'h0, 1'b1, 32'hA5A5_FFFC}) begin
      errors++;
      $display("[TB] FAIL pc_wrap got pc=%h pc4=%h v=%b inst=%h exp pc=00000000 pc4=00000000 v=1 inst=a5a5fffc",
               imem_addr, ifid_pc4, ifid_valid, ifid_inst);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    void'(expQ.pop_front());
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    e = expQ.pop_front();
    checks++;
    if ({imem_addr, ifid_inst, ifid_pc4, ifid_valid} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_mid_stall got pc=%h inst=%h pc4=%h v=%b exp all zero",
               imem_addr, ifid_inst, ifid_pc4, ifid_valid);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b0, ($urandom_range(3) == 0), ($urandom_range(7) == 0), $urandom,
                    ($urandom_range(3) == 0), 26'($urandom));
      e = expQ.pop_front();
      checks++;
      if ({imem_addr, ifid_inst, ifid_valid} !== {e.pc, e.inst, e.valid}
          || (e.valid && ifid_pc4 !== e.pc4)) begin
        errors++;
        $display("[TB] FAIL random[%0d] got pc=%h inst=%h pc4=%h v=%b exp pc=%h inst=%h pc4=%h v=%b",
                 i, imem_addr, ifid_inst, ifid_pc4, ifid_valid, e.pc, e.inst, e.pc4, e.valid);
      end
`ifdef IFID_PERF_CNT_EN
      checks++;
      if ({stall_cnt, flush_cnt} !== {e.sc, e.fc}) begin
        errors++;
        $display("[TB] FAIL random_cnt[%0d] got sc=%0d fc=%0d exp sc=%0d fc=%0d",
                 i, stall_cnt, flush_cnt, e.sc, e.fc);
      end
`endif
    end
  endtask

`ifdef IFID_PERF_CNT_EN
  task automatic test_perf();
    exp_t e;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    e = expQ.pop_front();
    checks++;
    if ({stall_cnt, flush_cnt} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL perf_reset got sc=%0d fc=%0d exp 0 0", stall_cnt, flush_cnt);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    void'(expQ.pop_front());
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
      void'(expQ.pop_front());
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 26'h0);
      e = expQ.pop_front();
    end
    checks++;
    if ({stall_cnt, flush_cnt} !== {32'd3, 32'd2} || {e.sc, e.fc} !== {32'd3, 32'd2}) begin
      errors++;
      $display("[TB] FAIL perf_counts got sc=%0d fc=%0d exp sc=3 fc=2", stall_cnt, flush_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    jump_en = 1'b0; jump_index = 26'h0;
    mPc = 32'h0; mInst = 32'h0; mPc4 = 32'h0; mValid = 1'b0; mSc = 32'h0; mFc = 32'h0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_branch_priority();
    test_wrap_reset();
    test_back_to_back();
`ifdef IFID_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
